// File: rtl/i_fetch.sv
// i_fetch: instruction fetch unit.
// Owns the PC, drives the instruction memory read port (one-cycle registered
// read latency) and hands {inst, pc} to decode over a valid/ready handshake
// through a 2-entry output buffer. Redirects flush everything and restart.
// Optional feature macro: IFU_MISALIGN_EN (misaligned redirect targets yield
// a single NOP entry flagged by inst_misaligned, then fetch halts).
module i_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc
`ifdef IFU_MISALIGN_EN
  ,
  output logic              inst_misaligned
`endif
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  typedef struct packed {
`ifdef IFU_MISALIGN_EN
    logic              mis;
`endif
    logic [31:0]       word;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  entry_t            head;
  entry_t            tail;
  logic              head_valid;
  logic              tail_valid;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] redirect_target;
  entry_t            push_entry;

`ifdef IFU_MISALIGN_EN
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  logic redirect_misaligned;
  logic mis_pending;
  logic halted;
`else
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(2'd3));
`endif

  // Handshake, issue credit, capture source and redirect target decode.
  always_comb begin
    pop        = head_valid & inst_ready;
    // Entries buffered or on their way after this edge; must stay below 2.
    occupancy  = {2'b00, head_valid} + {2'b00, tail_valid}
               + {2'b00, inflight} - {2'b00, pop};
    issue      = 1'b0;
    push       = inflight;
    push_entry = '0;
`ifdef IFU_MISALIGN_EN
    redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    redirect_target     = redirect_pc;
    if (!redirect_valid && !halted && (occupancy < 3'd2)) begin
      issue = 1'b1;
    end else begin
      issue = 1'b0;
    end
    if (mis_pending) begin
      push            = 1'b1;
      push_entry.mis  = 1'b1;
      push_entry.word = NOP_WORD;
      push_entry.pc   = pc;
    end else begin
      push_entry.mis  = 1'b0;
      push_entry.word = imem_rdata;
      push_entry.pc   = inflight_pc;
    end
`else
    // Low address bits are dropped so fetch always stays word aligned.
    redirect_target = redirect_pc & ALIGN_MASK;
    if (!redirect_valid && (occupancy < 3'd2)) begin
      issue = 1'b1;
    end else begin
      issue = 1'b0;
    end
    push_entry.word = imem_rdata;
    push_entry.pc   = inflight_pc;
`endif
  end

  // PC and outstanding-read tracking; redirect overrides any issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
`ifdef IFU_MISALIGN_EN
      mis_pending <= 1'b0;
      halted      <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc       <= redirect_target;
      inflight <= 1'b0;
`ifdef IFU_MISALIGN_EN
      mis_pending <= redirect_misaligned;
      halted      <= redirect_misaligned;
`endif
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + PC_STEP;
      end
`ifdef IFU_MISALIGN_EN
      mis_pending <= 1'b0;
`endif
    end
  end

  // Two-entry output buffer; head register drives decode directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
    end else if (redirect_valid) begin
      // A pop in this cycle still completes; everything else is discarded.
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
    end else begin
      case ({pop, push})
        2'b11: begin
          head <= tail_valid ? tail : push_entry;
          tail <= push_entry;
        end
        2'b10: begin
          head       <= tail;
          head_valid <= tail_valid;
          tail_valid <= 1'b0;
        end
        2'b01: begin
          if (head_valid) begin
            tail       <= push_entry;
            tail_valid <= 1'b1;
          end else begin
            head       <= push_entry;
            head_valid <= 1'b1;
          end
        end
        default: begin
          head_valid <= head_valid;
        end
      endcase
    end
  end

  assign imem_addr  = pc;
  assign inst_valid = head_valid;
  assign inst       = head.word;
  assign inst_pc    = head.pc;
`ifdef IFU_MISALIGN_EN
  assign inst_misaligned = head.mis;
`endif

endmodule
